// File: rtl/csync_sync_monitor.sv
// Composite-sync timing monitor: measures hsync period and lines per frame, qualifies lock, drives csync generator.
// Optional `CSYNC_LOCK_IRQ_EN adds a one-cycle lock_irq pulse after every change of locked.
module csync_sync_monitor #(
    parameter int PER_WIDTH      = 12,
    parameter int LINE_WIDTH     = 10,
    parameter int LOCK_FRAMES    = 4,
    parameter int PER_TOL        = 4,
    parameter int NTSC_MAX_LINES = 287
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hsync,
    input  logic                  vsync,
    output logic [PER_WIDTH-1:0]  line_period,
    output logic [LINE_WIDTH-1:0] line_count,
    output logic                  pal,
    output logic                  locked,
    output logic                  csync_en,
    output logic [PER_WIDTH-1:0]  pulse_width
`ifdef CSYNC_LOCK_IRQ_EN
    ,
    output logic                  lock_irq
`endif
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [PER_WIDTH-1:0]  TOL      = PER_WIDTH'(PER_TOL);
    localparam logic [LINE_WIDTH-1:0] NTSC_MAX = LINE_WIDTH'(NTSC_MAX_LINES);
    localparam logic [3:0]            LOCK_N   = 4'(LOCK_FRAMES);

    function automatic logic [PER_WIDTH-1:0] abs_diff(input logic [PER_WIDTH-1:0] a,
                                                      input logic [PER_WIDTH-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [1:0]            hs_s;
    logic [1:0]            vs_s;
    logic                  hs_fall;
    logic                  vs_fall;
    logic [PER_WIDTH-1:0]  per_cnt;
    logic                  per_sat;
    logic [LINE_WIDTH-1:0] line_cnt;
    logic [LINE_WIDTH-1:0] line_inc;
    logic                  have_period;
    logic                  line_bad;
    logic                  frame_ok;

    state_t                state;
    state_t                state_next;
    logic [3:0]            ok_cnt;
    logic [3:0]            ok_next;
    logic [3:0]            ok_inc;
    logic [LINE_WIDTH-1:0] prev_lines;
    logic [LINE_WIDTH-1:0] prev_next;
    logic                  frame_bad;
    logic                  bad_next;
    logic                  pal_next;
    logic [PER_WIDTH-1:0]  pw_next;

    assign hs_fall  = hs_s[1] & ~hs_s[0];
    assign vs_fall  = vs_s[1] & ~vs_s[0];
    assign per_sat  = &per_cnt;
    // The first line after SEARCH has no valid reference period to compare against.
    assign line_bad = hs_fall & have_period & (abs_diff(per_cnt, line_period) > TOL);
    // A line whose hsync fall coincides with vsync belongs to the frame that is ending.
    assign line_inc = (hs_fall && !(&line_cnt)) ? (line_cnt + LINE_WIDTH'(1)) : line_cnt;
    assign ok_inc   = ok_cnt + 4'd1;
    assign frame_ok = !(frame_bad | line_bad) && (line_inc == prev_lines) && (line_inc != '0);

    assign locked   = (state == LOCKED);
    assign csync_en = locked;

    // Input capture and measurement counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_s        <= 2'b11;
            vs_s        <= 2'b11;
            per_cnt     <= '0;
            line_period <= '0;
            line_cnt    <= '0;
            line_count  <= '0;
            have_period <= 1'b0;
        end else begin
            hs_s <= {hs_s[0], hsync};
            vs_s <= {vs_s[0], vsync};
            if (per_sat) begin
                per_cnt     <= '0;
                line_period <= '0;
                line_cnt    <= '0;
                line_count  <= '0;
                have_period <= 1'b0;
            end else begin
                if (hs_fall) begin
                    per_cnt     <= PER_WIDTH'(1);
                    line_period <= per_cnt;
                    have_period <= 1'b1;
                end else begin
                    per_cnt <= per_cnt + PER_WIDTH'(1);
                end
                if (vs_fall) begin
                    line_count <= line_inc;
                    line_cnt   <= '0;
                end else begin
                    line_cnt <= line_inc;
                end
            end
        end
    end

    // Lock qualification
    always_comb begin
        state_next = state;
        ok_next    = ok_cnt;
        prev_next  = prev_lines;
        bad_next   = frame_bad | line_bad;
        pal_next   = pal;
        pw_next    = pulse_width;
        if (per_sat) begin
            state_next = SEARCH;
            ok_next    = '0;
            prev_next  = '0;
            bad_next   = 1'b0;
            pal_next   = 1'b0;
            pw_next    = '0;
        end else if (vs_fall) begin
            bad_next = 1'b0;
            case (state)
                SEARCH: begin
                    state_next = TRACK;
                    ok_next    = '0;
                    prev_next  = '0;
                end
                TRACK: begin
                    prev_next = line_inc;
                    if (frame_ok) begin
                        ok_next = ok_inc;
                        if (ok_inc == LOCK_N) begin
                            state_next = LOCKED;
                            pal_next   = (line_inc > NTSC_MAX);
                            pw_next    = line_period >> 4;
                        end
                    end else begin
                        ok_next = '0;
                    end
                end
                LOCKED: begin
                    prev_next = line_inc;
                    if (!frame_ok) begin
                        state_next = TRACK;
                        ok_next    = '0;
                        pal_next   = 1'b0;
                    end
                end
                default: begin
                    state_next = SEARCH;
                    ok_next    = '0;
                    prev_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= SEARCH;
            ok_cnt      <= '0;
            prev_lines  <= '0;
            frame_bad   <= 1'b0;
            pal         <= 1'b0;
            pulse_width <= '0;
        end else begin
            state       <= state_next;
            ok_cnt      <= ok_next;
            prev_lines  <= prev_next;
            frame_bad   <= bad_next;
            pal         <= pal_next;
            pulse_width <= pw_next;
        end
    end

`ifdef CSYNC_LOCK_IRQ_EN
    logic locked_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            locked_d <= 1'b0;
            lock_irq <= 1'b0;
        end else begin
            locked_d <= locked;
            lock_irq <= (locked != locked_d);
        end
    end
`endif

endmodule

// File: tb/tb_csync_sync_monitor.sv
// Randomized self-checking bench for csync_sync_monitor with an event-level reference model.
// Frames are kept short (few lines, short NTSC/PAL threshold) so the run stays compact.
module tb_csync_sync_monitor;

    localparam int PER_W      = 12;
    localparam int LINE_W     = 10;
    localparam int LOCKF      = 4;
    localparam int TOL        = 4;
    localparam int NMAX       = 9;
    localparam int NTSC_LINES = 8;
    localparam int PAL_LINES  = 10;
    localparam int PERIOD     = 228;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              hsync = 1'b1;
    logic              vsync = 1'b1;
    logic [PER_W-1:0]  line_period;
    logic [LINE_W-1:0] line_count;
    logic              pal;
    logic              locked;
    logic              csync_en;
    logic [PER_W-1:0]  pulse_width;
`ifdef CSYNC_LOCK_IRQ_EN
    logic              lock_irq;
`endif

    csync_sync_monitor #(
        .PER_WIDTH(PER_W),
        .LINE_WIDTH(LINE_W),
        .LOCK_FRAMES(LOCKF),
        .PER_TOL(TOL),
        .NTSC_MAX_LINES(NMAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hsync(hsync),
        .vsync(vsync),
        .line_period(line_period),
        .line_count(line_count),
        .pal(pal),
        .locked(locked),
        .csync_en(csync_en),
        .pulse_width(pulse_width)
`ifdef CSYNC_LOCK_IRQ_EN
        ,
        .lock_irq(lock_irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int trans_q[$];
    int irq_q[$];
    logic last_locked = 1'b0;

    // reference model: 0 = searching, 1 = tracking, 2 = locked
    int m_state, m_lines, m_prev, m_ok, m_lp, m_pw, m_lc, m_trans;
    bit m_bad, m_have, m_pal;
    int prev_line_p = -1;
    int jit_cur = PERIOD;

    task automatic model_reset();
        m_state = 0; m_lines = 0; m_prev = 0; m_ok = 0; m_lp = 0;
        m_pw = 0; m_lc = 0; m_bad = 0; m_have = 0; m_pal = 0;
        prev_line_p = -1;
    endtask

    task automatic model_timeout();
        if (m_state == 2) m_trans++;
        model_reset();
    endtask

    // meas: length of the line that just ended, -1 when not a real line length
    task automatic model_hfall(input int meas);
        int d;
        d = (meas > m_lp) ? meas - m_lp : m_lp - meas;
        if (m_have && m_lp >= 0 && meas >= 0 && d > TOL) m_bad = 1;
        m_lp = (meas >= 0) ? meas : -1;
        m_have = 1;
        if (m_lines < (1 << LINE_W) - 1) m_lines++;
    endtask

    task automatic model_vfall();
        int lines;
        bit good;
        lines = m_lines;
        m_lc = lines;
        m_lines = 0;
        good = !m_bad && lines == m_prev && lines != 0;
        case (m_state)
            0: begin m_state = 1; m_ok = 0; m_prev = 0; m_bad = 0; end
            1: begin
                m_prev = lines; m_bad = 0;
                if (good) begin
                    m_ok++;
                    if (m_ok == LOCKF) begin
                        m_state = 2; m_pal = (lines > NMAX); m_pw = m_lp / 16; m_trans++;
                    end
                end else begin
                    m_ok = 0;
                end
            end
            default: begin
                m_prev = lines; m_bad = 0;
                if (!good) begin m_state = 1; m_ok = 0; m_pal = 0; m_trans++; end
            end
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (rst_n === 1'b1 && locked !== last_locked) trans_q.push_back(cyc);
        last_locked = locked;
`ifdef CSYNC_LOCK_IRQ_EN
        if (lock_irq === 1'b1) irq_q.push_back(cyc);
`endif
    endtask

    // One frame: vsync falls voff clocks after the first line's hsync fall.
    task automatic drive_frame(input int nlines, input int voff, input int glitch_line, input bit jitter);
        int p;
        for (int k = 0; k < nlines; k++) begin
            p = PERIOD;
            if (k == glitch_line) p = 235;
            if (jitter) begin
                jit_cur = jit_cur + int'($urandom_range(6)) - 3;
                if (jit_cur < PERIOD - 3) jit_cur = PERIOD - 3;
                if (jit_cur > PERIOD + 3) jit_cur = PERIOD + 3;
                p = jit_cur;
            end
            for (int c = 0; c < p; c++) begin
                if (c == 0) begin
                    hsync = 1'b0;
                    model_hfall(prev_line_p);
                    prev_line_p = p;
                end
                if (c == 16) hsync = 1'b1;
                if (k == 0 && c == voff) begin
                    vsync = 1'b0;
                    model_vfall();
                end
                if (k == 0 && c == voff + 20) vsync = 1'b1;
                step();
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        repeat (3) step();
        model_reset();
        checks++; if (line_period !== '0) begin errors++; $display("FAIL reset_line_period: got %0d expected 0", line_period); end
        checks++; if (line_count !== '0) begin errors++; $display("FAIL reset_line_count: got %0d expected 0", line_count); end
        checks++; if ({pal, locked, csync_en} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {pal, locked, csync_en}); end
        checks++; if (pulse_width !== '0) begin errors++; $display("FAIL reset_pulse_width: got %0d expected 0", pulse_width); end
`ifdef CSYNC_LOCK_IRQ_EN
        checks++; if (lock_irq !== 1'b0) begin errors++; $display("FAIL reset_lock_irq: got %b expected 0", lock_irq); end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ntsc_lock();
        int lock_at = 0;
        for (int i = 1; i <= 7; i++) begin
            drive_frame(NTSC_LINES, 50, -1, 0);
            checks++;
            if (locked !== (m_state == 2) || csync_en !== (m_state == 2)) begin
                errors++;
                $display("FAIL ntsc_lock frame %0d: got locked %b csync_en %b expected %0d", i, locked, csync_en, m_state == 2);
            end
            if (lock_at == 0 && locked === 1'b1) lock_at = i;
        end
        checks++; if (lock_at != LOCKF + 2) begin errors++; $display("FAIL ntsc_lock_latency: got vsync %0d expected %0d", lock_at, LOCKF + 2); end
        checks++; if (line_count !== NTSC_LINES) begin errors++; $display("FAIL ntsc_line_count: got %0d expected %0d", line_count, NTSC_LINES); end
        checks++; if (line_period !== PERIOD) begin errors++; $display("FAIL ntsc_line_period: got %0d expected %0d", line_period, PERIOD); end
        checks++; if (pal !== 1'b0) begin errors++; $display("FAIL ntsc_pal: got %b expected 0", pal); end
        checks++; if (pulse_width !== 14) begin errors++; $display("FAIL ntsc_pulse_width: got %0d expected 14", pulse_width); end
    endtask

    task automatic test_line_glitch();
        drive_frame(NTSC_LINES, 50, 3, 0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL glitch_pre: got locked %b expected 1", locked); end
        for (int i = 1; i <= 5; i++) begin
            drive_frame(NTSC_LINES, 50, -1, 0);
            checks++;
            if (locked !== (i >= 5) || csync_en !== (i >= 5)) begin
                errors++;
                $display("FAIL glitch_relock frame %0d: got locked %b csync_en %b expected %0d", i, locked, csync_en, i >= 5);
            end
        end
    endtask

    task automatic test_jitter();
        jit_cur = PERIOD;
        for (int i = 1; i <= 4; i++) begin
            drive_frame(NTSC_LINES, 50, -1, 1);
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL jitter_locked frame %0d: got %b expected 1", i, locked); end
            checks++; if (line_period !== m_lp) begin errors++; $display("FAIL jitter_line_period frame %0d: got %0d expected %0d", i, line_period, m_lp); end
        end
        checks++; if (pulse_width !== m_pw) begin errors++; $display("FAIL jitter_pulse_width: got %0d expected %0d", pulse_width, m_pw); end
    endtask

    task automatic test_coincident();
        for (int i = 1; i <= 3; i++) begin
            drive_frame(NTSC_LINES, 0, -1, 0);
            checks++; if (line_count !== NTSC_LINES) begin errors++; $display("FAIL coincident_line_count frame %0d: got %0d expected %0d", i, line_count, NTSC_LINES); end
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL coincident_locked frame %0d: got %b expected 1", i, locked); end
        end
    endtask

    task automatic test_timeout();
        hsync = 1'b1;
        vsync = 1'b1;
        repeat (4300) step();
        model_timeout();
        checks++; if ({pal, locked, csync_en} !== 3'b000) begin errors++; $display("FAIL timeout_flags: got %b expected 000", {pal, locked, csync_en}); end
        checks++; if (line_period !== '0 || line_count !== '0) begin errors++; $display("FAIL timeout_counts: got period %0d lines %0d expected 0 0", line_period, line_count); end
        checks++; if (pulse_width !== '0) begin errors++; $display("FAIL timeout_pulse_width: got %0d expected 0", pulse_width); end
        for (int i = 1; i <= 6; i++) begin
            drive_frame(NTSC_LINES, 50, -1, 0);
            checks++;
            if (locked !== (m_state == 2) || locked !== (i >= 6)) begin
                errors++;
                $display("FAIL timeout_relock frame %0d: got %b expected %0d", i, locked, i >= 6);
            end
        end
        checks++; if (line_count !== m_lc) begin errors++; $display("FAIL timeout_relock_lines: got %0d expected %0d", line_count, m_lc); end
    endtask

    task automatic test_pal();
        int lock_at = 0;
        rst_n = 1'b0;
        repeat (3) step();
        model_reset();
        checks++; if (locked !== 1'b0 || line_count !== '0) begin errors++; $display("FAIL pal_reset: got locked %b lines %0d expected 0 0", locked, line_count); end
        rst_n = 1'b1;
        step();
        for (int i = 1; i <= 6; i++) begin
            drive_frame(PAL_LINES, 50, -1, 0);
            checks++; if (locked !== (m_state == 2)) begin errors++; $display("FAIL pal_lock frame %0d: got %b expected %0d", i, locked, m_state == 2); end
            if (lock_at == 0 && locked === 1'b1) lock_at = i;
        end
        checks++; if (lock_at != LOCKF + 2) begin errors++; $display("FAIL pal_lock_latency: got vsync %0d expected %0d", lock_at, LOCKF + 2); end
        checks++; if (pal !== 1'b1) begin errors++; $display("FAIL pal_flag: got %b expected 1", pal); end
        checks++; if (line_count !== PAL_LINES) begin errors++; $display("FAIL pal_line_count: got %0d expected %0d", line_count, PAL_LINES); end
        checks++; if (pulse_width !== 14) begin errors++; $display("FAIL pal_pulse_width: got %0d expected 14", pulse_width); end
    endtask

    task automatic test_lock_irq();
        checks++;
        if (trans_q.size() != m_trans) begin
            errors++;
            $display("FAIL lock_transitions: got %0d expected %0d", trans_q.size(), m_trans);
        end
`ifdef CSYNC_LOCK_IRQ_EN
        checks++;
        if (irq_q.size() != trans_q.size()) begin
            errors++;
            $display("FAIL lock_irq_count: got %0d expected %0d", irq_q.size(), trans_q.size());
        end else begin
            foreach (trans_q[i]) begin
                checks++;
                if (irq_q[i] != trans_q[i] + 1) begin
                    errors++;
                    $display("FAIL lock_irq_timing %0d: got cycle %0d expected %0d", i, irq_q[i], trans_q[i] + 1);
                end
            end
        end
`endif
    endtask

    initial begin
        m_trans = 0;
        model_reset();
        test_reset();
        test_ntsc_lock();
        test_line_glitch();
        test_jitter();
        test_coincident();
        test_timeout();
        test_pal();
        test_lock_irq();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
